ram_dp_be: RTL

RAM_DP_BE -- requirements
Module: ram_dp_be

---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_dp_core.sv | 29 ++
 rtl/ram_dp_be.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types for the byte-enabled dual-port RAM: FSM state encoding and
// the per-lane even-parity helper.
package ram_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Widest byte lane the parity helper accepts; narrower lanes are zero-extended.
   localparam int MAX_LANE_W = 64;

   function automatic logic lane_parity(input logic [MAX_LANE_W-1:0] lane);
      return ^lane;
   endfunction

endpackage

// File: rtl/ram_dp_core.sv
// Reset-free storage array: one per-lane masked write port and one
// combinational read port. Lanes may carry a parity bit above the data byte.
module ram_dp_core #(
   parameter int ADDR_WIDTH = 8,
   parameter int NB         = 4,
   parameter int LANE_W     = 8
) (
   input  logic                          clk,
   input  logic                          we,
   input  logic [NB-1:0]                 be,
   input  logic [ADDR_WIDTH-1:0]         waddr,
   input  logic [NB-1:0][LANE_W-1:0]     wdata,
   input  logic [ADDR_WIDTH-1:0]         raddr,
   output logic [NB-1:0][LANE_W-1:0]     rdata
);

   logic [NB-1:0][LANE_W-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem[waddr][i] <= wdata[i];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ram_dp_be.sv
// Byte-enabled dual-port RAM with power-up clear FSM, write-first forwarding
// and a 1- or 2-stage read pipeline. Optional lane parity via RAM_PARITY_EN.
module ram_dp_be
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int OUT_REG    = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             we,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
   input  logic [ADDR_WIDTH-1:0]            waddr,
   input  logic [DATA_WIDTH-1:0]            din,
   input  logic                             re,
   input  logic [ADDR_WIDTH-1:0]            raddr,
   output logic [DATA_WIDTH-1:0]            dout,
   output logic                             dout_valid,
   output logic                             init_busy,
   output logic                             par_err
);

   localparam int NB = DATA_WIDTH / BYTE_WIDTH;
`ifdef RAM_PARITY_EN
   localparam int PW = 1;
`else
   localparam int PW = 0;
`endif
   localparam int LW = BYTE_WIDTH + PW;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    in_init, rd_acc, wr_hit;

   logic [NB-1:0][BYTE_WIDTH-1:0] din_l;
   logic [NB-1:0][LW-1:0]         usr_lane, merged;
   logic [NB-1:0][LW-1:0]         core_wdata, core_rdata;
   logic                          core_we;
   logic [NB-1:0]                 core_be;
   logic [ADDR_WIDTH-1:0]         core_waddr;
   logic [DATA_WIDTH-1:0]         rd_data;

   logic [OUT_REG:0]                 vld_pipe_q, vld_pipe_d;
   logic [OUT_REG:0][DATA_WIDTH-1:0] data_pipe_q, data_pipe_d;

   assign din_l   = din;
   assign in_init = (state_q == ST_INIT);
   assign rd_acc  = re & ~in_init;
   assign wr_hit  = we & ~in_init & (waddr == raddr);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + ADDR_WIDTH'(1);
         if (&cnt_q) state_d = ST_READY;
      end
   end

   always_comb begin
      usr_lane = '0;
      for (int i = 0; i < NB; i++) begin
         usr_lane[i][BYTE_WIDTH-1:0] = din_l[i];
`ifdef RAM_PARITY_EN
         usr_lane[i][BYTE_WIDTH] = lane_parity(MAX_LANE_W'(din_l[i]));
`endif
      end
   end

   // The clear sweep owns the write port; user writes are dropped meanwhile.
   always_comb begin
      core_we    = in_init | we;
      core_be    = in_init ? '1 : be;
      core_waddr = in_init ? cnt_q : waddr;
      core_wdata = in_init ? '0 : usr_lane;
   end

   ram_dp_core #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NB         (NB),
      .LANE_W     (LW)
   ) u_core (
      .clk   (clk),
      .we    (core_we),
      .be    (core_be),
      .waddr (core_waddr),
      .wdata (core_wdata),
      .raddr (raddr),
      .rdata (core_rdata)
   );

`ifdef RAM_PARITY_EN
   logic rd_err;
`endif

   // Write-first: lanes being written on the same edge come from din.
   always_comb begin
      merged  = core_rdata;
      rd_data = '0;
`ifdef RAM_PARITY_EN
      rd_err  = 1'b0;
`endif
      for (int i = 0; i < NB; i++) begin
         if (wr_hit && be[i]) merged[i] = usr_lane[i];
         rd_data[i*BYTE_WIDTH +: BYTE_WIDTH] = merged[i][BYTE_WIDTH-1:0];
`ifdef RAM_PARITY_EN
         rd_err = rd_err |
                  (merged[i][BYTE_WIDTH] ^ lane_parity(MAX_LANE_W'(merged[i][BYTE_WIDTH-1:0])));
`endif
      end
   end

   // Data stages only load on a valid beat so dout holds between reads.
   always_comb begin
      vld_pipe_d     = vld_pipe_q;
      data_pipe_d    = data_pipe_q;
      vld_pipe_d[0]  = rd_acc;
      data_pipe_d[0] = rd_acc ? rd_data : data_pipe_q[0];
      for (int k = 1; k <= OUT_REG; k++) begin
         vld_pipe_d[k]  = vld_pipe_q[k-1];
         data_pipe_d[k] = vld_pipe_q[k-1] ? data_pipe_q[k-1] : data_pipe_q[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         vld_pipe_q  <= '0;
         data_pipe_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         vld_pipe_q  <= vld_pipe_d;
         data_pipe_q <= data_pipe_d;
      end
   end

   assign dout       = data_pipe_q[OUT_REG];
   assign dout_valid = vld_pipe_q[OUT_REG];
   assign init_busy  = in_init;

`ifdef RAM_PARITY_EN
   logic [OUT_REG:0] err_pipe_q, err_pipe_d;

   always_comb begin
      err_pipe_d    = err_pipe_q;
      err_pipe_d[0] = rd_acc ? rd_err : err_pipe_q[0];
      for (int k = 1; k <= OUT_REG; k++) begin
         err_pipe_d[k] = vld_pipe_q[k-1] ? err_pipe_q[k-1] : err_pipe_q[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_pipe_q <= '0;
      else        err_pipe_q <= err_pipe_d;
   end

   assign par_err = vld_pipe_q[OUT_REG] & err_pipe_q[OUT_REG];
`else
   assign par_err = 1'b0;
`endif

endmodule
